// File: rtl/digit_pkg.sv
// Shared types and constants for the digit demux loader.
package digit_pkg;

   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 4;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [1:0] {
      StFill,
      StFull,
      StCopy
   } state_e;

endpackage

// File: rtl/digit_reg4.sv
// Four-entry nibble register bank: single indexed write or load of all entries at once.
module digit_reg4
   import digit_pkg::*;
#(
   parameter digit_t RESET_DIGIT = 4'h0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [1:0]                 widx,
   input  digit_t                     wdata,
   input  logic                       load_all,
   input  digit_t [NUM_DIGITS-1:0]    load_data,
   output digit_t [NUM_DIGITS-1:0]    q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= {NUM_DIGITS{RESET_DIGIT}};
      end else if (load_all) begin
         q <= load_data;
      end else if (we) begin
         q[widx] <= wdata;
      end
   end

endmodule

// File: rtl/digit_demux_loader.sv
// Streams 4-bit digits into four display registers A..D with an auto pointer and commit strobe.
// Define DIGIT_DOUBLE_BUFFER_EN to stage writes and publish them to A..D only on commit.
module digit_demux_loader
   import digit_pkg::*;
#(
   parameter digit_t RESET_DIGIT = 4'h0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         addr_en,
   input  logic [1:0]   addr,
   input  logic         commit,
   output logic [3:0]   A,
   output logic [3:0]   B,
   output logic [3:0]   C,
   output logic [3:0]   D,
   output logic [1:0]   ptr,
   output logic         frame_done
);

   state_e                  state_q, state_d;
   logic [1:0]              ptr_q, ptr_d;
   logic                    frame_done_q;
   logic                    accept;
   logic                    auto_wr;
   logic                    auto_wrap;
   logic                    commit_take;
   logic [1:0]              widx;
   digit_t [NUM_DIGITS-1:0] out_q;

   assign accept      = din_valid && din_ready;
   assign auto_wr     = accept && !addr_en;
   assign auto_wrap   = auto_wr && (ptr_q == 2'd3);
   assign commit_take = commit && (state_q != StCopy);
   assign widx        = addr_en ? addr : ptr_q;

   always_comb begin
      state_d   = state_q;
      din_ready = 1'b0;
      unique case (state_q)
         StFill: begin
            din_ready = 1'b1;
            if (commit) begin
               state_d = StCopy;
            end else if (auto_wrap) begin
               state_d = StFull;
            end
         end
         StFull: begin
            if (commit) begin
               state_d = StCopy;
            end
         end
         StCopy: begin
            state_d = StFill;
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      if (commit_take) begin
         ptr_d = 2'd0;
      end else if (auto_wr) begin
         ptr_d = ptr_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StFill;
         ptr_q        <= 2'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         frame_done_q <= auto_wrap;
      end
   end

`ifdef DIGIT_DOUBLE_BUFFER_EN
   digit_t [NUM_DIGITS-1:0] stage_q;
   digit_t [NUM_DIGITS-1:0] merged;

   // A write accepted on the commit edge must appear in the published copy.
   always_comb begin
      merged = stage_q;
      if (accept) begin
         merged[widx] = din;
      end
   end

   digit_reg4 #(
      .RESET_DIGIT (RESET_DIGIT)
   ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (accept),
      .widx      (widx),
      .wdata     (din),
      .load_all  (1'b0),
      .load_data ('0),
      .q         (stage_q)
   );

   digit_reg4 #(
      .RESET_DIGIT (RESET_DIGIT)
   ) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (1'b0),
      .widx      (2'd0),
      .wdata     ('0),
      .load_all  (commit_take),
      .load_data (merged),
      .q         (out_q)
   );
`else
   digit_reg4 #(
      .RESET_DIGIT (RESET_DIGIT)
   ) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (accept),
      .widx      (widx),
      .wdata     (din),
      .load_all  (1'b0),
      .load_data ('0),
      .q         (out_q)
   );
`endif

   assign A          = out_q[0];
   assign B          = out_q[1];
   assign C          = out_q[2];
   assign D          = out_q[3];
   assign ptr        = ptr_q;
   assign frame_done = frame_done_q;

endmodule
